// File: rtl/spi_slave_word.sv
// SPI slave exchanging C-bit words MSB first, all four CPOL/CPHA modes.
// Everything runs on CLK_IN; SPI_CLK, SPI_SS and MOSI are oversampled.
module spi_slave_word #(
  parameter int unsigned C    = 16,
  parameter int unsigned SYNC = 2
) (
  input  logic         CLK_IN,
  input  logic         RST_N,
  input  logic         SPI_CLK,
  input  logic         SPI_SS,
  input  logic         MOSI,
  output logic         MISO,
  output logic         MISO_OE,
  input  logic         CPOL,
  input  logic         CPHA,
  input  logic [C-1:0] din,
  output logic         load,
  output logic [C-1:0] dout,
  output logic         valid,
  output logic         abort
);

  localparam int unsigned CW = $clog2(C);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC-1:0] clk_sync_q, ss_sync_q, mosi_sync_q;
  logic            clk_hist_q, ss_filt_q, ss_hist_q;

  state_t          state_q, state_d;
  logic            cpol_q, cpol_d, cpha_q, cpha_d;
  logic [C-1:0]    tx_q, tx_d;
  logic [C-2:0]    rx_q, rx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            miso_q, miso_d, oe_q, oe_d;
  logic [C-1:0]    dout_q, dout_d;
  logic            valid_q, valid_d, load_q, load_d, abort_q, abort_d;

  logic            clk_s_c, mosi_s_c, clk_chg_c, lead_c, trail_c;
  logic            ss_fall_c, ss_rise_c, sample_c, drive_c;
  logic [C-1:0]    word_c;

  // Synchronizers; SS only changes once every stage agrees, which filters short glitches.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      clk_hist_q  <= 1'b0;
      ss_filt_q   <= 1'b1;
      ss_hist_q   <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC-2:0], SPI_CLK};
      ss_sync_q   <= {ss_sync_q[SYNC-2:0], SPI_SS};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], MOSI};
      clk_hist_q  <= clk_sync_q[SYNC-1];
      if (&ss_sync_q) begin
        ss_filt_q <= 1'b1;
      end else if (~|ss_sync_q) begin
        ss_filt_q <= 1'b0;
      end
      ss_hist_q   <= ss_filt_q;
    end
  end

  assign clk_s_c   = clk_sync_q[SYNC-1];
  assign mosi_s_c  = mosi_sync_q[SYNC-1];
  assign clk_chg_c = clk_s_c ^ clk_hist_q;
  assign lead_c    = clk_chg_c & (clk_s_c != cpol_q);
  assign trail_c   = clk_chg_c & (clk_s_c == cpol_q);
  assign ss_fall_c = ss_hist_q & ~ss_filt_q;
  assign ss_rise_c = ~ss_hist_q & ss_filt_q;
  assign sample_c  = cpha_q ? trail_c : lead_c;
  assign drive_c   = cpha_q ? lead_c : trail_c;
  assign word_c    = {rx_q, mosi_s_c};

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    load_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        cpol_d = CPOL;
        cpha_d = CPHA;
        if (ss_fall_c) begin
          state_d = ACTIVE;
          tx_d    = din;
          load_d  = 1'b1;
          oe_d    = 1'b1;
          miso_d  = din[C-1];
          cnt_d   = '0;
        end
      end

      ACTIVE: begin
        if (sample_c) begin
          rx_d = (C-1)'(word_c);
          if (cnt_q == CW'(C - 1)) begin
            dout_d  = word_c;
            valid_d = 1'b1;
            cnt_d   = '0;
            tx_d    = din;
            load_d  = 1'b1;
            if (!cpha_q) begin
              miso_d = din[C-1];
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (drive_c) begin
          // CPHA=1 re-presents the preloaded MSB on a word's first leading edge;
          // CPHA=0 skips the trailing edge right after a completed word.
          if (cpha_q && (cnt_q == '0)) begin
            miso_d = tx_q[C-1];
          end else if (cpha_q || (cnt_q != '0)) begin
            tx_d   = {tx_q[C-2:0], 1'b0};
            miso_d = tx_q[C-2];
          end
        end

        if (ss_rise_c) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          abort_d = (cnt_d != '0);
          cnt_d   = '0;
          rx_d    = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign MISO    = miso_q;
  assign MISO_OE = oe_q;
  assign dout    = dout_q;
  assign valid   = valid_q;
  assign load    = load_q;
  assign abort   = abort_q;

endmodule
